// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmit-side word feeder.
//   - UART_DATA_W   : transmitter data-input width, used as the default word width
//   - feeder_state_t: launch sequencer state encoding
//   - OVF_CNT_MAX   : saturation value of the optional dropped-write counter
//                     (only used when UART_TXFEED_OVF_CNT_EN is defined)
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 32;

    localparam logic [15:0] OVF_CNT_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } feeder_state_t;

endpackage : uart_pkg

// File: rtl/uart_txq_mem.sv
// -----------------------------------------------------------------------------
// uart_txq_mem
//   DEPTH x DATA_W register array backing the word feeder queue.
//   Synchronous write, combinational read. Pointers and fill count live in the
//   parent; this block holds storage only. Contents are not reset, because the
//   parent's fill count decides which entries are valid.
//
// Ports
//   clk    in   1        write clock, rising edge
//   we     in   1        write enable
//   waddr  in   PTR_W    write address
//   wdata  in   DATA_W   write data
//   raddr  in   PTR_W    read address
//   rdata  out  DATA_W   entry at raddr (combinational)
// -----------------------------------------------------------------------------
module uart_txq_mem
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : uart_txq_mem

// File: rtl/uart_tx_word_feeder.sv
// -----------------------------------------------------------------------------
// uart_tx_word_feeder
//   Queues host words and launches them one at a time into the UART
//   transmitter: the head word is registered onto Tx_data, a one-cycle
//   Tx_start pulse follows, and the sequencer waits for the transmitter's busy
//   flag to rise and then fall before taking the next word.
//
// Ports
//   Clock_In    in   1       system clock, rising edge
//   Reset       in   1       asynchronous, active-high; clears all state
//   Wr_valid    in   1       host presents Wr_data
//   Wr_data     in   DATA_W  word to transmit
//   Wr_ready    out  1       queue can accept (transfer on Wr_valid && Wr_ready)
//   Tx_busy     in   1       transmitter frame in progress (synchronous)
//   Tx_data     out  DATA_W  registered word to transmitter, held until next pop
//   Tx_start    out  1       one-cycle launch pulse
//   Fill_level  out  CNT_W   words stored, 0..DEPTH
//   Empty       out  1       Fill_level == 0
//   Full        out  1       Fill_level == DEPTH
//   Ovf_count   out  16      writes dropped while Full, saturating
//                            (present only with UART_TXFEED_OVF_CNT_EN defined)
//
// Build option
//   UART_TXFEED_OVF_CNT_EN : adds the Ovf_count port and its counter.
//
// Sequencer states
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | waiting for a queued word; pops head into Tx_data
//   LAUNCH    | word on Tx_data; Tx_start is raised on leaving this state
//   WAIT_ACK  | waiting for the transmitter to report busy (no timeout)
//   WAIT_DONE | frame in progress; waiting for busy to drop
// -----------------------------------------------------------------------------
module uart_tx_word_feeder
    import uart_pkg::*;
#(
    parameter  int DATA_W = UART_DATA_W,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              Clock_In,
    input  logic              Reset,
    input  logic              Wr_valid,
    input  logic [DATA_W-1:0] Wr_data,
    output logic              Wr_ready,
    input  logic              Tx_busy,
    output logic [DATA_W-1:0] Tx_data,
    output logic              Tx_start,
    output logic [CNT_W-1:0]  Fill_level,
    output logic              Empty,
    output logic              Full
`ifdef UART_TXFEED_OVF_CNT_EN
    ,
    output logic [15:0]       Ovf_count
`endif
);

    localparam int PTR_W = CNT_W - 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              wr_en;
    logic              pop;
    logic              tx_start_nxt;
    logic [DATA_W-1:0] head;

    feeder_state_t state;
    feeder_state_t state_nxt;

    // ------------------------------------------------------------------
    // Queue bookkeeping
    // ------------------------------------------------------------------
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Full is taken from the registered count, so a write arriving while
    // Full is dropped even if the sequencer pops in the same cycle.
    assign wr_en = Wr_valid && !full;

    assign Wr_ready   = !full;
    assign Full       = full;
    assign Empty      = empty;
    assign Fill_level = count;

    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    uart_txq_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (Clock_In),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (Wr_data),
        .raddr (rd_ptr),
        .rdata (head)
    );

    // ------------------------------------------------------------------
    // Launch sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        pop          = 1'b0;
        tx_start_nxt = 1'b0;
        case (state)
            IDLE: begin
                // Pop is gated by the registered count only: a word written
                // on this edge is not visible until the next cycle.
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_start_nxt = 1'b1;
                state_nxt    = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (Tx_busy) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!Tx_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            Tx_start <= 1'b0;
            Tx_data  <= '0;
        end else begin
            state    <= state_nxt;
            Tx_start <= tx_start_nxt;
            if (pop) begin
                Tx_data <= head;
            end
        end
    end

`ifdef UART_TXFEED_OVF_CNT_EN
    // ------------------------------------------------------------------
    // Dropped-write counter: every cycle the host offers a word while
    // Full counts once, saturating rather than wrapping.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock_In or posedge Reset) begin
        if (Reset) begin
            Ovf_count <= '0;
        end else if (Wr_valid && full && (Ovf_count != OVF_CNT_MAX)) begin
            Ovf_count <= Ovf_count + 16'd1;
        end
    end
`endif

endmodule : uart_tx_word_feeder

// File: tb/tb_uart_tx_word_feeder.sv
module tb_uart_tx_word_feeder;
    import uart_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              tx_busy;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic [CNT_W-1:0]  fill_level;
    logic              empty;
    logic              full;
`ifdef UART_TXFEED_OVF_CNT_EN
    logic [15:0]       ovf_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Transmitter model: busy for frame_len cycles after seeing Tx_start.
    // In manual mode the bench drives busy directly.
    int   frame_len   = 5;
    int   busy_cnt    = 0;
    logic model_busy  = 1'b0;
    logic manual_busy = 1'b0;
    logic use_manual  = 1'b1;

    logic [DATA_W-1:0] launched[$];

    assign tx_busy = use_manual ? manual_busy : model_busy;

    always #5 clk = ~clk;

    uart_tx_word_feeder dut (
        .Clock_In   (clk),
        .Reset      (rst),
        .Wr_valid   (wr_valid),
        .Wr_data    (wr_data),
        .Wr_ready   (wr_ready),
        .Tx_busy    (tx_busy),
        .Tx_data    (tx_data),
        .Tx_start   (tx_start),
        .Fill_level (fill_level),
        .Empty      (empty),
        .Full       (full)
`ifdef UART_TXFEED_OVF_CNT_EN
        ,
        .Ovf_count  (ovf_count)
`endif
    );

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else if (busy_cnt != 0) begin
            busy_cnt = busy_cnt - 1;
        end else if (tx_start === 1'b1) begin
            busy_cnt = frame_len;
        end
        model_busy = (busy_cnt != 0);
    end

    always @(negedge clk) begin
        if (tx_start === 1'b1) launched.push_back(tx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic write_word(input logic [DATA_W-1:0] d);
        wr_data  = d;
        wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
        use_manual = 1'b1; manual_busy = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_vec++; if (tx_data !== 32'd0) begin n_err++; $display("FAIL reset_tx_data: got %0d want 0", tx_data); end
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
        n_vec++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL reset_fill: got %0d want 0", fill_level); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
`ifdef UART_TXFEED_OVF_CNT_EN
        n_vec++; if (ovf_count !== 16'd0) begin n_err++; $display("FAIL reset_ovf: got %0d want 0", ovf_count); end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        use_manual = 1'b0; frame_len = 5;
        launched.delete();
        write_word(32'd8900);
        n_vec++; if (fill_level !== 4'd1) begin n_err++; $display("FAIL single_fill_after_write: got %0d want 1", fill_level); end
        @(negedge clk);
        n_vec++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL single_fill_after_pop: got %0d want 0", fill_level); end
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_early: got %b want 0", tx_start); end
        @(negedge clk);
        n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL single_start: got %b want 1", tx_start); end
        n_vec++; if (tx_data !== 32'd8900) begin n_err++; $display("FAIL single_data: got %0d want 8900", tx_data); end
        @(negedge clk);
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL single_start_width: got %b want 0", tx_start); end
        repeat (20) @(negedge clk);
        n_vec++; if (launched.size() != 1) begin n_err++; $display("FAIL single_launch_count: got %0d want 1", launched.size()); end
        n_vec++; if (tx_data !== 32'd8900) begin n_err++; $display("FAIL single_data_held: got %0d want 8900", tx_data); end
    endtask

    task automatic test_back_to_back;
        use_manual = 1'b0; frame_len = 100;
        launched.delete();
        // Prime a long frame so the next 8 words all sit in the queue.
        write_word(32'd8899);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            wr_data  = 32'd8900 + 32'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        n_vec++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL b2b_fill: got %0d want 8", fill_level); end
        n_vec++; if (full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", full); end
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_wr_ready: got %b want 0", wr_ready); end
    endtask

    task automatic test_overflow;
        int k;
        write_word(32'd9999);
        n_vec++; if (fill_level !== 4'd8) begin n_err++; $display("FAIL ovf_fill: got %0d want 8", fill_level); end
`ifdef UART_TXFEED_OVF_CNT_EN
        n_vec++; if (ovf_count !== 16'd1) begin n_err++; $display("FAIL ovf_count: got %0d want 1", ovf_count); end
`endif
        k = 0;
        while (launched.size() < 9 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        n_vec++; if (k >= 3000) begin n_err++; $display("FAIL ovf_drain_timeout: got %0d launches want 9", launched.size()); end
        repeat (120) @(negedge clk);
        n_vec++; if (launched.size() != 9) begin n_err++; $display("FAIL ovf_launch_count: got %0d want 9", launched.size()); end
        for (int i = 0; i < 9; i++) begin
            if (i < launched.size()) begin
                n_vec++;
                if (launched[i] !== 32'd8899 + 32'(i)) begin
                    n_err++; $display("FAIL order_%0d: got %0d want %0d", i, launched[i], 8899 + i);
                end
            end
        end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_wrap;
        // Advance the pointers to 6 so the five words below cross index 7 -> 0.
        use_manual = 1'b0; frame_len = 3;
        launched.delete();
        for (int i = 0; i < 4; i++) begin
            wr_data  = 32'h100 + 32'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        repeat (60) @(negedge clk);
        n_vec++; if (launched.size() != 4) begin n_err++; $display("FAIL wrap_pre_count: got %0d want 4", launched.size()); end

        launched.delete();
        manual_busy = 1'b0; use_manual = 1'b1;
        write_word(32'hA0);
        repeat (2) @(negedge clk);
        manual_busy = 1'b1;
        for (int i = 1; i < 4; i++) begin
            wr_data  = 32'hA0 + 32'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        n_vec++; if (fill_level !== 4'd3) begin n_err++; $display("FAIL wrap_fill3: got %0d want 3", fill_level); end
        manual_busy = 1'b0;
        @(negedge clk);
        n_vec++; if (fill_level !== 4'd3) begin n_err++; $display("FAIL wrap_fill_idle: got %0d want 3", fill_level); end
        wr_data = 32'hA4; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
        n_vec++; if (fill_level !== 4'd3) begin n_err++; $display("FAIL wrap_fill_wr_pop: got %0d want 3", fill_level); end
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL wrap_start_early: got %b want 0", tx_start); end
        @(negedge clk);
        n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL wrap_start: got %b want 1", tx_start); end
        n_vec++; if (tx_data !== 32'hA1) begin n_err++; $display("FAIL wrap_data: got %h want a1", tx_data); end
        use_manual = 1'b0;
        repeat (60) @(negedge clk);
        n_vec++; if (launched.size() != 5) begin n_err++; $display("FAIL wrap_launch_count: got %0d want 5", launched.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < launched.size()) begin
                n_vec++;
                if (launched[i] !== 32'hA0 + 32'(i)) begin
                    n_err++; $display("FAIL wrap_order_%0d: got %h want %h", i, launched[i], 32'hA0 + 32'(i));
                end
            end
        end
    endtask

    task automatic test_reset_midframe;
        use_manual = 1'b1; manual_busy = 1'b0;
        write_word(32'hB0);
        repeat (2) @(negedge clk);
        manual_busy = 1'b1;
        for (int i = 1; i < 5; i++) begin
            wr_data  = 32'hB0 + 32'(i);
            wr_valid = 1'b1;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (fill_level !== 4'd4) begin n_err++; $display("FAIL mid_fill_before: got %0d want 4", fill_level); end
        rst = 1'b1;
        #1;
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL mid_tx_start: got %b want 0", tx_start); end
        n_vec++; if (empty !== 1'b1) begin n_err++; $display("FAIL mid_empty: got %b want 1", empty); end
        n_vec++; if (fill_level !== 4'd0) begin n_err++; $display("FAIL mid_fill: got %0d want 0", fill_level); end
        n_vec++; if (tx_data !== 32'd0) begin n_err++; $display("FAIL mid_tx_data: got %h want 0", tx_data); end
`ifdef UART_TXFEED_OVF_CNT_EN
        n_vec++; if (ovf_count !== 16'd0) begin n_err++; $display("FAIL mid_ovf: got %0d want 0", ovf_count); end
`endif
        @(negedge clk);
        manual_busy = 1'b0;
        rst = 1'b0;
        launched.delete();
        repeat (20) @(negedge clk);
        n_vec++; if (launched.size() != 0) begin n_err++; $display("FAIL mid_spurious_launch: got %0d want 0", launched.size()); end
        write_word(32'hC0);
        repeat (2) @(negedge clk);
        n_vec++; if (tx_start !== 1'b1) begin n_err++; $display("FAIL mid_relaunch_start: got %b want 1", tx_start); end
        n_vec++; if (tx_data !== 32'hC0) begin n_err++; $display("FAIL mid_relaunch_data: got %h want c0", tx_data); end
    endtask

    task automatic test_no_ack;
        // Busy stays low after the C0 launch: sequencer must sit in WAIT_ACK.
        @(negedge clk);
        n_vec++; if (tx_start !== 1'b0) begin n_err++; $display("FAIL noack_start_drop: got %b want 0", tx_start); end
        write_word(32'hC1);
        repeat (50) @(negedge clk);
        n_vec++; if (fill_level !== 4'd1) begin n_err++; $display("FAIL noack_fill: got %0d want 1", fill_level); end
        n_vec++; if (launched.size() != 1) begin n_err++; $display("FAIL noack_launch_count: got %0d want 1", launched.size()); end
        n_vec++; if (tx_data !== 32'hC0) begin n_err++; $display("FAIL noack_data_held: got %h want c0", tx_data); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_reset_midframe();
        test_no_ack();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx_word_feeder
